ulpi_tx_link: RTL and testbench
===============================

// Module: ulpi_tx_link
// PURPOSE
//   Link-side ULPI transmit engine: opposite direction of the ULPI receive path in top.
//   Takes a PID plus a byte stream from the packet layer and drives a ULPI PHY.
//   Sends the TX CMD byte, streams data bytes paced by ulpi_nxt and ends the packet with ulpi_stp.
//   Yields the bus whenever the PHY asserts ulpi_dir. Runs in the ULPI clock domain (60 MHz).
// PARAMETERS
//   RETRY_LIMIT  4  max TX CMD preemptions by ulpi_dir before packet abandoned (1..15)
// PORTS
//   clk            in   1  ULPI clock, all logic on rising edge
//   n_rst          in   1  asynchronous active-low reset
//   tx_start       in   1  request packet send; sampled only in IDLE
//   tx_pid         in   4  USB PID, latched on accepted tx_start
//   tx_hs_only     in   1  PID-only (handshake/token-less) packet, latched with tx_start
//   tx_data        in   8  payload byte, valid with tx_valid
//   tx_valid       in   1  tx_data holds a byte
//   tx_last        in   1  current tx_data byte is final payload byte
//   tx_ready       out  1  current tx_data byte consumed this cycle
//   tx_busy        out  1  packet in progress (state != IDLE)
//   tx_done        out  1  1-cycle pulse: packet completed normally
//   tx_abort       out  1  1-cycle pulse: packet abandoned; upstream flushes remaining bytes
//   ulpi_dir       in   1  PHY owns bus when 1
//   ulpi_nxt       in   1  PHY accepted byte on bus this cycle
//   ulpi_data_out  out  8  link-driven ULPI data
//   ulpi_data_oe   out  1  link drives ulpi data bus
//   ulpi_stp       out  1  ULPI stop
// BEHAVIOUR
// - Reset (n_rst=0, async): state=IDLE, retry_cnt=0, dir_q=0.
//   All outputs 0; data_out=8'h00.
// - bus_ok = !ulpi_dir && !dir_q; dir_q is ulpi_dir registered (1-cycle turnaround after dir falls).
//   ulpi_data_oe = 1 only in CMD/DATA/STP/ABRT and only while ulpi_dir=0.
// - IDLE: tx_start=1 latches pid/hs_only, clears retry_cnt -> WAIT_BUS.
//   tx_start in any other state ignored.
// - WAIT_BUS: bus_ok -> CMD next cycle; else hold.
// - CMD: data_out = {2'b01,2'b00,pid}.
//   - ulpi_dir=1 (takes priority over nxt): retry_cnt++ -> WAIT_BUS.
//     If retry_cnt reaches RETRY_LIMIT, pulse tx_abort -> IDLE instead.
//   - else ulpi_nxt=1: -> STP if hs_only, else -> DATA.
// - DATA: data_out = tx_data (combinational pass-through).
//   - ulpi_dir=1: tx_abort pulse, oe=0, -> IDLE (no stp).
//   - ulpi_nxt=1 & tx_valid=1: tx_ready=1 same cycle; tx_last=1 -> STP, else stay DATA.
//   - ulpi_nxt=1 & tx_valid=0: underrun -> ABRT.
//   - ulpi_nxt=0: hold; tx_ready=0, data_out follows tx_data.
// - STP: ulpi_stp=1, data_out=8'h00 for exactly 1 cycle.
//   Pulse tx_done -> IDLE. ulpi_dir=1 here: tx_abort instead of tx_done.
// - ABRT: ulpi_stp=1, data_out=8'hFF for 1 cycle (ULPI link abort).
//   Pulse tx_abort -> IDLE.
// - tx_ready only ever high in DATA with nxt=1, dir=0, tx_valid=1.
//   Exactly one tx_ready per payload byte.
// - tx_done/tx_abort mutually exclusive; exactly one per accepted tx_start.
//   Each is a registered pulse, asserted the cycle after the leaving state.
// - tx_busy=1 from the cycle after tx_start acceptance until the cycle state returns to IDLE.
// - Reset mid-packet: bus released (oe=0, stp=0) immediately.
//   No done/abort pulse issued.
// TESTING
// 1. pid=4'h3 (DATA0), 3 bytes A1,B2,C3, nxt always 1:
//    data_out=43,A1,B2,C3,00; stp on last cycle; tx_ready x3; tx_done x1.
// 2. hs_only, pid=4'h2 (ACK), nxt=1 after 2 wait cycles:
//    42 held 3 cycles, then 00 with stp=1; tx_done; no tx_ready.
// 3. nxt toggled 1,0,0,1,1 during 2-byte payload:
//    each byte held until nxt; tx_ready only on nxt cycles; byte order preserved.
// 4. dir=1 for 2 cycles while in CMD:
//    oe=0, TX CMD reissued on the 2nd cycle after dir falls; packet completes with tx_done.
//    RETRY_LIMIT preemptions in CMD -> tx_abort, no stp.
// 5. tx_valid=0 with nxt=1 mid-payload:
//    next cycle data_out=FF, stp=1; tx_abort pulse; back in IDLE (tx_busy=0) after.
// 6. n_rst low during DATA:
//    all outputs 0 asynchronously; new tx_start after release sends a clean packet.

Source files
------------

// File: rtl/ulpi_tx_link.sv
`default_nettype none
// ============================================================================
// Module   : ulpi_tx_link
// Purpose  : Link-side ULPI transmit engine. Takes a PID plus a byte stream
//            from the packet layer and drives a ULPI PHY: sends the TX CMD
//            byte, streams payload bytes paced by ulpi_nxt, and ends the
//            packet with ulpi_stp. Yields the bus whenever the PHY asserts
//            ulpi_dir. Runs entirely in the 60 MHz ULPI clock domain.
// Ports    : clk, n_rst                      - ULPI clock, async active-low reset
//            tx_start/tx_pid/tx_hs_only      - packet request (sampled in IDLE)
//            tx_data/tx_valid/tx_last        - payload byte stream
//            tx_ready                        - payload byte consumed this cycle
//            tx_busy/tx_done/tx_abort        - packet status and completion pulses
//            ulpi_dir/ulpi_nxt               - PHY bus direction / byte accept
//            ulpi_data_out/ulpi_data_oe/ulpi_stp - link-driven ULPI signals
// Revision : 1.0 - initial release
// ============================================================================
module ulpi_tx_link #(
    parameter int RETRY_LIMIT = 4  // TX CMD preemptions tolerated (1..15)
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic       tx_hs_only,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_abort,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    output logic [7:0] ulpi_data_out,
    output logic       ulpi_data_oe,
    output logic       ulpi_stp
);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_wait_bus = 3'd1;
    localparam logic [2:0] c_st_cmd      = 3'd2;
    localparam logic [2:0] c_st_data     = 3'd3;
    localparam logic [2:0] c_st_stp      = 3'd4;
    localparam logic [2:0] c_st_abrt     = 3'd5;

    localparam logic [3:0] c_retry_limit = 4'(RETRY_LIMIT);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [3:0] r_retry_cnt;
    logic [3:0] w_retry_cnt_nxt;
    logic [3:0] r_pid;
    logic       r_hs_only;
    logic       r_dir_q;
    logic       r_done;
    logic       r_abort;
    logic       w_done_nxt;
    logic       w_abort_nxt;
    logic       w_latch;
    logic       w_bus_ok;
    logic       w_drive;

    // The PHY needs one turnaround cycle after releasing the bus, so the
    // link waits until dir has been low for both this and the last cycle.
    assign w_bus_ok = !ulpi_dir && !r_dir_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= c_st_idle;
            r_retry_cnt <= 4'd0;
            r_pid       <= 4'd0;
            r_hs_only   <= 1'b0;
            r_dir_q     <= 1'b0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_retry_cnt <= w_retry_cnt_nxt;
            r_dir_q     <= ulpi_dir;
            r_done      <= w_done_nxt;
            r_abort     <= w_abort_nxt;
            if (w_latch) begin
                r_pid     <= tx_pid;
                r_hs_only <= tx_hs_only;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic (also computes the pulses registered next cycle)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_retry_cnt_nxt = r_retry_cnt;
        w_done_nxt      = 1'b0;
        w_abort_nxt     = 1'b0;
        w_latch         = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (tx_start) begin
                    w_latch         = 1'b1;
                    w_retry_cnt_nxt = 4'd0;
                    w_state_nxt     = c_st_wait_bus;
                end
            end
            c_st_wait_bus: begin
                if (w_bus_ok) begin
                    w_state_nxt = c_st_cmd;
                end
            end
            c_st_cmd: begin
                // Losing the bus outranks a simultaneous nxt.
                if (ulpi_dir) begin
                    w_retry_cnt_nxt = r_retry_cnt + 4'd1;
                    if (r_retry_cnt + 4'd1 == c_retry_limit) begin
                        w_abort_nxt = 1'b1;
                        w_state_nxt = c_st_idle;
                    end else begin
                        w_state_nxt = c_st_wait_bus;
                    end
                end else if (ulpi_nxt) begin
                    w_state_nxt = r_hs_only ? c_st_stp : c_st_data;
                end
            end
            c_st_data: begin
                if (ulpi_dir) begin
                    // PHY took the bus mid-payload: drop out without stp.
                    w_abort_nxt = 1'b1;
                    w_state_nxt = c_st_idle;
                end else if (ulpi_nxt) begin
                    if (tx_valid) begin
                        if (tx_last) begin
                            w_state_nxt = c_st_stp;
                        end
                    end else begin
                        w_state_nxt = c_st_abrt;
                    end
                end
            end
            c_st_stp: begin
                w_done_nxt  = !ulpi_dir;
                w_abort_nxt = ulpi_dir;
                w_state_nxt = c_st_idle;
            end
            c_st_abrt: begin
                w_abort_nxt = 1'b1;
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        ulpi_data_out = 8'h00;
        ulpi_stp      = 1'b0;
        tx_ready      = 1'b0;
        w_drive       = 1'b0;
        case (r_state)
            c_st_cmd: begin
                ulpi_data_out = {2'b01, 2'b00, r_pid};
                w_drive       = 1'b1;
            end
            c_st_data: begin
                ulpi_data_out = tx_data;
                w_drive       = 1'b1;
                tx_ready      = ulpi_nxt && !ulpi_dir && tx_valid;
            end
            c_st_stp: begin
                ulpi_stp = 1'b1;
                w_drive  = 1'b1;
            end
            c_st_abrt: begin
                ulpi_data_out = 8'hFF;
                ulpi_stp      = 1'b1;
                w_drive       = 1'b1;
            end
            default: begin
                w_drive = 1'b0;
            end
        endcase
    end

    assign ulpi_data_oe = w_drive && !ulpi_dir;
    assign tx_busy      = (r_state != c_st_idle);
    assign tx_done      = r_done;
    assign tx_abort     = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_ulpi_tx_link.sv
`default_nettype none
// ============================================================================
// Module   : tb_ulpi_tx_link
// Purpose  : Directed self-checking bench for ulpi_tx_link. Each scenario
//            task holds a per-cycle table of input vectors and hand-derived
//            expected output words and compares them inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ulpi_tx_link;

    logic       clk;
    logic       n_rst;
    logic       tx_start;
    logic [3:0] tx_pid;
    logic       tx_hs_only;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_abort;
    logic       ulpi_dir;
    logic       ulpi_nxt;
    logic [7:0] ulpi_data_out;
    logic       ulpi_data_oe;
    logic       ulpi_stp;

    int n_checks;
    int n_fail;

    ulpi_tx_link #(.RETRY_LIMIT(4)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .tx_start      (tx_start),
        .tx_pid        (tx_pid),
        .tx_hs_only    (tx_hs_only),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_last       (tx_last),
        .tx_ready      (tx_ready),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .tx_abort      (tx_abort),
        .ulpi_dir      (ulpi_dir),
        .ulpi_nxt      (ulpi_nxt),
        .ulpi_data_out (ulpi_data_out),
        .ulpi_data_oe  (ulpi_data_oe),
        .ulpi_stp      (ulpi_stp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus word: {start, nxt, dir, valid, last, data}
    function automatic logic [12:0] S(input logic st, input logic nx, input logic dr,
                                      input logic vl, input logic ls, input logic [7:0] d);
        return {st, nx, dr, vl, ls, d};
    endfunction

    // Expected word: {data_out, oe, stp, ready, busy, done, abort}
    function automatic logic [13:0] E(input logic [7:0] d, input logic oe, input logic sp,
                                      input logic rd, input logic bz, input logic dn,
                                      input logic ab);
        return {d, oe, sp, rd, bz, dn, ab};
    endfunction

    function automatic logic [13:0] obs();
        return {ulpi_data_out, ulpi_data_oe, ulpi_stp, tx_ready, tx_busy, tx_done, tx_abort};
    endfunction

    // Apply one cycle of stimulus on the falling edge and let it settle.
    task automatic drive(input logic [12:0] s);
        @(negedge clk);
        {tx_start, ulpi_nxt, ulpi_dir, tx_valid, tx_last, tx_data} = s;
        #1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        {tx_start, ulpi_nxt, ulpi_dir, tx_valid, tx_last, tx_data} = 13'd0;
        tx_pid = 4'h0;
        tx_hs_only = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_async got=%h exp=%h", obs(), 14'd0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(S(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
            n_checks++;
            if (obs() !== 14'd0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d got=%h exp=%h", i, obs(), 14'd0);
            end
        end
        n_rst = 1'b1;
    endtask

    task automatic test_basic_data0();
        logic [12:0] s [9];
        logic [13:0] e [9];
        tx_pid = 4'h3;
        tx_hs_only = 1'b0;
        s = '{S(1,0,0,0,0,8'h00), S(0,0,0,0,0,8'h00), S(0,1,0,1,0,8'hA1),
              S(0,1,0,1,0,8'hA1), S(0,1,0,1,0,8'hB2), S(0,1,0,1,1,8'hC3),
              S(0,1,0,0,0,8'h00), S(0,0,0,0,0,8'h00), S(0,0,0,0,0,8'h00)};
        e = '{E(8'h00,0,0,0,0,0,0), E(8'h00,0,0,0,1,0,0), E(8'h43,1,0,0,1,0,0),
              E(8'hA1,1,0,1,1,0,0), E(8'hB2,1,0,1,1,0,0), E(8'hC3,1,0,1,1,0,0),
              E(8'h00,1,1,0,1,0,0), E(8'h00,0,0,0,0,1,0), E(8'h00,0,0,0,0,0,0)};
        for (int i = 0; i < 9; i++) begin
            drive(s[i]);
            n_checks++;
            if (obs() !== e[i]) begin
                n_fail++;
                $display("FAIL basic_data0 cyc%0d got=%h exp=%h", i, obs(), e[i]);
            end
        end
    endtask

    task automatic test_handshake();
        logic [12:0] s [8];
        logic [13:0] e [8];
        tx_pid = 4'h2;
        tx_hs_only = 1'b1;
        s = '{S(1,0,0,0,0,8'h00), S(0,0,0,0,0,8'h00), S(0,0,0,0,0,8'h00),
              S(0,0,0,0,0,8'h00), S(0,1,0,0,0,8'h00), S(0,0,0,0,0,8'h00),
              S(0,0,0,0,0,8'h00), S(0,0,0,0,0,8'h00)};
        e = '{E(8'h00,0,0,0,0,0,0), E(8'h00,0,0,0,1,0,0), E(8'h42,1,0,0,1,0,0),
              E(8'h42,1,0,0,1,0,0), E(8'h42,1,0,0,1,0,0), E(8'h00,1,1,0,1,0,0),
              E(8'h00,0,0,0,0,1,0), E(8'h00,0,0,0,0,0,0)};
        for (int i = 0; i < 8; i++) begin
            drive(s[i]);
            n_checks++;
            if (obs() !== e[i]) begin
                n_fail++;
                $display("FAIL handshake cyc%0d got=%h exp=%h", i, obs(), e[i]);
            end
        end
    endtask

    // nxt pattern 1,0,0,1,1 from the CMD cycle; a stray tx_start mid-payload
    // must not disturb the packet.
    task automatic test_nxt_pacing();
        logic [12:0] s [9];
        logic [13:0] e [9];
        tx_pid = 4'hB;
        tx_hs_only = 1'b0;
        s = '{S(1,0,0,0,0,8'h00), S(0,0,0,0,0,8'h00), S(0,1,0,1,0,8'hD4),
              S(0,0,0,1,0,8'hD4), S(1,0,0,1,0,8'hD4), S(0,1,0,1,0,8'hD4),
              S(0,1,0,1,1,8'hE5), S(0,0,0,0,0,8'h00), S(0,0,0,0,0,8'h00)};
        e = '{E(8'h00,0,0,0,0,0,0), E(8'h00,0,0,0,1,0,0), E(8'h4B,1,0,0,1,0,0),
              E(8'hD4,1,0,0,1,0,0), E(8'hD4,1,0,0,1,0,0), E(8'hD4,1,0,1,1,0,0),
              E(8'hE5,1,0,1,1,0,0), E(8'h00,1,1,0,1,0,0), E(8'h00,0,0,0,0,1,0)};
        for (int i = 0; i < 9; i++) begin
            drive(s[i]);
            n_checks++;
            if (obs() !== e[i]) begin
                n_fail++;
                $display("FAIL nxt_pacing cyc%0d got=%h exp=%h", i, obs(), e[i]);
            end
        end
        drive(S(0,0,0,0,0,8'h00));
        n_checks++;
        if (obs() !== E(8'h00,0,0,0,0,0,0)) begin
            n_fail++;
            $display("FAIL nxt_pacing_idle got=%h exp=%h", obs(), E(8'h00,0,0,0,0,0,0));
        end
    endtask

    // One preemption in CMD: TX CMD reissued two cycles after dir falls.
    task automatic test_dir_preempt();
        logic [12:0] s [10];
        logic [13:0] e [10];
        tx_pid = 4'h2;
        tx_hs_only = 1'b1;
        s = '{S(1,0,0,0,0,8'h00), S(0,0,0,0,0,8'h00), S(0,0,1,0,0,8'h00),
              S(0,0,1,0,0,8'h00), S(0,0,0,0,0,8'h00), S(0,0,0,0,0,8'h00),
              S(0,1,0,0,0,8'h00), S(0,0,0,0,0,8'h00), S(0,0,0,0,0,8'h00),
              S(0,0,0,0,0,8'h00)};
        e = '{E(8'h00,0,0,0,0,0,0), E(8'h00,0,0,0,1,0,0), E(8'h42,0,0,0,1,0,0),
              E(8'h00,0,0,0,1,0,0), E(8'h00,0,0,0,1,0,0), E(8'h00,0,0,0,1,0,0),
              E(8'h42,1,0,0,1,0,0), E(8'h00,1,1,0,1,0,0), E(8'h00,0,0,0,0,1,0),
              E(8'h00,0,0,0,0,0,0)};
        for (int i = 0; i < 10; i++) begin
            drive(s[i]);
            n_checks++;
            if (obs() !== e[i]) begin
                n_fail++;
                $display("FAIL dir_preempt cyc%0d got=%h exp=%h", i, obs(), e[i]);
            end
        end
    endtask

    // Four preemptions in CMD exhaust the retry budget: abort, never stp.
    task automatic test_retry_abort();
        logic [12:0] s [14];
        logic [13:0] e [14];
        tx_pid = 4'h2;
        tx_hs_only = 1'b1;
        for (int i = 0; i < 14; i++) begin
            s[i] = S(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            e[i] = E(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        s[0]  = S(1,0,0,0,0,8'h00);
        e[0]  = E(8'h00,0,0,0,0,0,0);
        s[2]  = S(0,0,1,0,0,8'h00);  e[2]  = E(8'h42,0,0,0,1,0,0);
        s[5]  = S(0,0,1,0,0,8'h00);  e[5]  = E(8'h42,0,0,0,1,0,0);
        s[8]  = S(0,0,1,0,0,8'h00);  e[8]  = E(8'h42,0,0,0,1,0,0);
        s[11] = S(0,0,1,0,0,8'h00);  e[11] = E(8'h42,0,0,0,1,0,0);
        e[12] = E(8'h00,0,0,0,0,0,1);
        e[13] = E(8'h00,0,0,0,0,0,0);
        for (int i = 0; i < 14; i++) begin
            drive(s[i]);
            n_checks++;
            if (obs() !== e[i]) begin
                n_fail++;
                $display("FAIL retry_abort cyc%0d got=%h exp=%h", i, obs(), e[i]);
            end
        end
    endtask

    task automatic test_dir_in_data();
        logic [12:0] s [6];
        logic [13:0] e [6];
        tx_pid = 4'h3;
        tx_hs_only = 1'b0;
        s = '{S(1,0,0,0,0,8'h00), S(0,0,0,0,0,8'h00), S(0,1,0,1,0,8'h66),
              S(0,0,1,1,0,8'h66), S(0,0,0,0,0,8'h00), S(0,0,0,0,0,8'h00)};
        e = '{E(8'h00,0,0,0,0,0,0), E(8'h00,0,0,0,1,0,0), E(8'h43,1,0,0,1,0,0),
              E(8'h66,0,0,0,1,0,0), E(8'h00,0,0,0,0,0,1), E(8'h00,0,0,0,0,0,0)};
        for (int i = 0; i < 6; i++) begin
            drive(s[i]);
            n_checks++;
            if (obs() !== e[i]) begin
                n_fail++;
                $display("FAIL dir_in_data cyc%0d got=%h exp=%h", i, obs(), e[i]);
            end
        end
    endtask

    task automatic test_underrun();
        logic [12:0] s [8];
        logic [13:0] e [8];
        tx_pid = 4'h3;
        tx_hs_only = 1'b0;
        s = '{S(1,0,0,0,0,8'h00), S(0,0,0,0,0,8'h00), S(0,1,0,1,0,8'h11),
              S(0,1,0,1,0,8'h11), S(0,1,0,0,0,8'h22), S(0,0,0,0,0,8'h00),
              S(0,0,0,0,0,8'h00), S(0,0,0,0,0,8'h00)};
        e = '{E(8'h00,0,0,0,0,0,0), E(8'h00,0,0,0,1,0,0), E(8'h43,1,0,0,1,0,0),
              E(8'h11,1,0,1,1,0,0), E(8'h22,1,0,0,1,0,0), E(8'hFF,1,1,0,1,0,0),
              E(8'h00,0,0,0,0,0,1), E(8'h00,0,0,0,0,0,0)};
        for (int i = 0; i < 8; i++) begin
            drive(s[i]);
            n_checks++;
            if (obs() !== e[i]) begin
                n_fail++;
                $display("FAIL underrun cyc%0d got=%h exp=%h", i, obs(), e[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [12:0] s [4];
        logic [13:0] e [4];
        logic [12:0] s2 [7];
        logic [13:0] e2 [7];
        tx_pid = 4'h3;
        tx_hs_only = 1'b0;
        s = '{S(1,0,0,0,0,8'h00), S(0,0,0,0,0,8'h00), S(0,1,0,1,0,8'h55),
              S(0,0,0,1,0,8'h55)};
        e = '{E(8'h00,0,0,0,0,0,0), E(8'h00,0,0,0,1,0,0), E(8'h43,1,0,0,1,0,0),
              E(8'h55,1,0,0,1,0,0)};
        for (int i = 0; i < 4; i++) begin
            drive(s[i]);
            n_checks++;
            if (obs() !== e[i]) begin
                n_fail++;
                $display("FAIL rst_mid_pre cyc%0d got=%h exp=%h", i, obs(), e[i]);
            end
        end
        #2;
        n_rst = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 14'd0) begin
            n_fail++;
            $display("FAIL rst_mid_async got=%h exp=%h", obs(), 14'd0);
        end
        drive(S(0,0,0,0,0,8'h00));
        n_checks++;
        if (obs() !== 14'd0) begin
            n_fail++;
            $display("FAIL rst_mid_hold got=%h exp=%h", obs(), 14'd0);
        end
        n_rst = 1'b1;
        s2 = '{S(1,0,0,0,0,8'h00), S(0,0,0,0,0,8'h00), S(0,1,0,1,1,8'h77),
               S(0,1,0,1,1,8'h77), S(0,0,0,0,0,8'h00), S(0,0,0,0,0,8'h00),
               S(0,0,0,0,0,8'h00)};
        e2 = '{E(8'h00,0,0,0,0,0,0), E(8'h00,0,0,0,1,0,0), E(8'h43,1,0,0,1,0,0),
               E(8'h77,1,0,1,1,0,0), E(8'h00,1,1,0,1,0,0), E(8'h00,0,0,0,0,1,0),
               E(8'h00,0,0,0,0,0,0)};
        for (int i = 0; i < 7; i++) begin
            drive(s2[i]);
            n_checks++;
            if (obs() !== e2[i]) begin
                n_fail++;
                $display("FAIL rst_mid_post cyc%0d got=%h exp=%h", i, obs(), e2[i]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_data0();
        test_handshake();
        test_nxt_pacing();
        test_dir_preempt();
        test_retry_abort();
        test_dir_in_data();
        test_underrun();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
